// File: rtl/sb_spi_pkg.sv
// sb_spi_pkg: register offsets, SPISR bit positions, bus direction codes and bus FSM states
package sb_spi_pkg;
  localparam logic [3:0] SPICR0  = 4'h8;
  localparam logic [3:0] SPICR1  = 4'h9;
  localparam logic [3:0] SPICR2  = 4'hA;
  localparam logic [3:0] SPIBR   = 4'hB;
  localparam logic [3:0] SPISR   = 4'hC;
  localparam logic [3:0] SPITXDR = 4'hD;
  localparam logic [3:0] SPIRXDR = 4'hE;
  localparam logic [3:0] SPICSR  = 4'hF;
  localparam int SR_TIP  = 7;
  localparam int SR_BUSY = 6;
  localparam int SR_TOE  = 5;
  localparam int SR_TRDY = 4;
  localparam int SR_RRDY = 3;
  localparam int SR_ROE  = 2;
  localparam logic SB_WR = 1'b1;
  localparam logic SB_RD = 1'b0;
  typedef enum logic [1:0] {BUS_IDLE, BUS_ACK, BUS_WAIT} bus_state_e;
endpackage

// File: rtl/sb_spi_shifter.sv
// sb_spi_shifter: SPI slave pin synchronisers, edge detect, bit counter and shift registers; SB_SPI_MODES_EN enables CPOL/CPHA
module sb_spi_shifter
  import sb_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       spe_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       lsbf_i,
  input  logic       spi_sck_i,
  input  logic       spi_ss_i,
  input  logic       spi_si_i,
  input  logic [7:0] tx_i,
  output logic       byte_start_o,
  output logic       byte_done_o,
  output logic [7:0] rx_o,
  output logic       tip_o,
  output logic       ss_low_o,
  output logic       spi_so_o
);
  logic [2:0] s1_q, s2_q, cnt_q, cnt_d;
  logic [1:0] prev_q, prev_d;
  logic [7:0] sh_q, sh_d, rx_q, rx_d;
  logic       act_q, act_d;
  logic       sck, ss, si, lead, trail, ss_fall, run, smp, shf;
`ifndef SB_SPI_MODES_EN
  logic       unused_mode;
`endif
  // Edge decode and next-state of the engine; act_q only rises on a seen ss fall, so a
  // reset in mid-transfer waits for the next frame (sync flops reset low to avoid a false fall)
  always_comb begin
    ss = s2_q[1];
    si = s2_q[0];
`ifdef SB_SPI_MODES_EN
    sck = s2_q[2] ^ cpol_i;
`else
    sck = s2_q[2];
    unused_mode = cpol_i ^ cpha_i;
`endif
    lead = sck & ~prev_q[1];
    trail = ~sck & prev_q[1];
    ss_fall = prev_q[0] & ~ss;
    run = act_q & spe_i & ~ss;
`ifdef SB_SPI_MODES_EN
    smp = run & (cpha_i ? trail : lead);
    shf = run & (cpha_i ? lead : trail);
`else
    smp = run & lead;
    shf = run & trail;
`endif
    rx_d = smp ? (lsbf_i ? {si, rx_q[7:1]} : {rx_q[6:0], si}) : rx_q;
    byte_done_o = smp & (cnt_q == 3'd7);
    byte_start_o = (ss_fall & spe_i) | byte_done_o;
    cnt_d = run ? cnt_q + {2'b00, smp} : 3'd0;
    act_d = spe_i & ~ss & (act_q | ss_fall);
    sh_d = byte_start_o ? tx_i :
           (shf && cnt_q != 3'd0) ? (lsbf_i ? {1'b0, sh_q[7:1]} : {sh_q[6:0], 1'b0}) : sh_q;
    prev_d = {sck, ss};
    rx_o = rx_d;
    tip_o = cnt_q != 3'd0;
    ss_low_o = ~ss;
    spi_so_o = run ? (lsbf_i ? sh_q[0] : sh_q[7]) : 1'b1;
  end
  // Synchroniser chain and engine state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 3'b000;
      s2_q <= 3'b000;
      prev_q <= 2'b00;
      cnt_q <= 3'd0;
      sh_q <= 8'h00;
      rx_q <= 8'h00;
      act_q <= 1'b0;
    end else begin
      s1_q <= {spi_sck_i, spi_ss_i, spi_si_i};
      s2_q <= s1_q;
      prev_q <= prev_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
      act_q <= act_d;
    end
  end
endmodule

// File: rtl/sb_spi.sv
// sb_spi: iCE40-style hard SPI slave with 8-bit system-bus registers; define SB_SPI_MODES_EN for CPOL/CPHA support
module sb_spi
  import sb_spi_pkg::*;
#(
  parameter logic [3:0] BUS_ADDR74 = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sbrwi,
  input  logic       sbstbi,
  input  logic [7:0] sbadri,
  input  logic [7:0] sbdati,
  output logic [7:0] sbdato,
  output logic       sbacko,
  input  logic       spi_sck,
  input  logic       spi_ss,
  input  logic       spi_si,
  output logic       spi_so
);
  bus_state_e st_q, st_d;
  logic [7:0] cr0_q, cr0_d, cr1_q, cr1_d, cr2_q, cr2_d, br_q, br_d, csr_q, csr_d;
  logic [7:0] hold_q, hold_d, rxdr_q, rxdr_d, sr, rdata, rx_byte;
  logic       trdy_q, trdy_d, rrdy_q, rrdy_d, toe_q, toe_d, roe_q, roe_d;
  logic       wr, rd, byte_start, byte_done, tip, ss_low;
  logic [3:0] a;
  sb_spi_shifter u_shf (
    .clk(clk), .rst(rst), .spe_i(cr1_q[7]), .cpol_i(cr2_q[2]), .cpha_i(cr2_q[1]),
    .lsbf_i(cr2_q[0]), .spi_sck_i(spi_sck), .spi_ss_i(spi_ss), .spi_si_i(spi_si),
    .tx_i(trdy_q ? 8'h00 : hold_q), .byte_start_o(byte_start), .byte_done_o(byte_done),
    .rx_o(rx_byte), .tip_o(tip), .ss_low_o(ss_low), .spi_so_o(spi_so)
  );
  // Bus FSM: one-cycle ack, then hold off until the strobe is seen low
  always_comb begin
    st_d = st_q == BUS_IDLE ? ((sbstbi && sbadri[7:4] == BUS_ADDR74) ? BUS_ACK : BUS_IDLE) :
           sbstbi ? BUS_WAIT : BUS_IDLE;
    sbacko = st_q == BUS_ACK;
    sbdato = sbacko ? rdata : 8'h00;
  end
  // Status word and register read mux
  always_comb begin
    a = sbadri[3:0];
    sr = 8'h00;
    sr[SR_TIP] = tip;
    sr[SR_BUSY] = tip | ss_low;
    sr[SR_TOE] = toe_q;
    sr[SR_TRDY] = trdy_q;
    sr[SR_RRDY] = rrdy_q;
    sr[SR_ROE] = roe_q;
    case (a)
      SPICR0:  rdata = cr0_q;
      SPICR1:  rdata = cr1_q;
      SPICR2:  rdata = cr2_q;
      SPIBR:   rdata = br_q;
      SPISR:   rdata = sr;
      SPIRXDR: rdata = rxdr_q;
      SPICSR:  rdata = csr_q;
      default: rdata = 8'h00;
    endcase
  end
  // Register writes and flag updates; a TX write beats a same-cycle transfer, a landing byte beats an RX read
  always_comb begin
    wr = sbacko && sbrwi == SB_WR;
    rd = sbacko && sbrwi == SB_RD;
    cr0_d = (wr && a == SPICR0) ? sbdati : cr0_q;
    cr1_d = (wr && a == SPICR1) ? sbdati : cr1_q;
    cr2_d = (wr && a == SPICR2) ? sbdati : cr2_q;
    br_d = (wr && a == SPIBR) ? sbdati : br_q;
    csr_d = (wr && a == SPICSR) ? sbdati : csr_q;
    hold_d = (wr && a == SPITXDR) ? sbdati : hold_q;
    trdy_d = (wr && a == SPITXDR) ? 1'b0 : byte_start ? 1'b1 : trdy_q;
    toe_d = (byte_start && trdy_q) ? 1'b1 : (rd && a == SPISR) ? 1'b0 : toe_q;
    rxdr_d = byte_done ? rx_byte : rxdr_q;
    rrdy_d = byte_done ? 1'b1 : (rd && a == SPIRXDR) ? 1'b0 : rrdy_q;
    roe_d = (byte_done && rrdy_q && !(rd && a == SPIRXDR)) ? 1'b1 : (rd && a == SPISR) ? 1'b0 : roe_q;
  end
  // State and register storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= BUS_IDLE;
      cr0_q <= 8'h00;
      cr1_q <= 8'h00;
      cr2_q <= 8'h00;
      br_q <= 8'h00;
      csr_q <= 8'h00;
      hold_q <= 8'h00;
      rxdr_q <= 8'h00;
      trdy_q <= 1'b1;
      rrdy_q <= 1'b0;
      toe_q <= 1'b0;
      roe_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cr0_q <= cr0_d;
      cr1_q <= cr1_d;
      cr2_q <= cr2_d;
      br_q <= br_d;
      csr_q <= csr_d;
      hold_q <= hold_d;
      rxdr_q <= rxdr_d;
      trdy_q <= trdy_d;
      rrdy_q <= rrdy_d;
      toe_q <= toe_d;
      roe_q <= roe_d;
    end
  end
endmodule

// File: tb/tb_sb_spi.sv
// tb_sb_spi: scoreboard bench for sb_spi with a behavioural register/flag model and a bit-banged SPI master
module tb_sb_spi;
  import sb_spi_pkg::*;
  logic clk = 0, rst = 1, sbrwi = 0, sbstbi = 0, spi_sck = 0, spi_ss = 1, spi_si = 0;
  logic [7:0] sbadri = 0, sbdati = 0, sbdato;
  logic sbacko, spi_so;
  int errs = 0, checks = 0;
  logic [7:0] exp_q[$];
  string nm_q[$];
  logic [7:0] m_reg[16];
  logic [7:0] m_hold, m_rx, m_cur;
  bit m_full, m_rrdy, m_toe, m_roe;

  sb_spi #(.BUS_ADDR74(4'h0)) dut (
    .clk(clk), .rst(rst), .sbrwi(sbrwi), .sbstbi(sbstbi), .sbadri(sbadri), .sbdati(sbdati),
    .sbdato(sbdato), .sbacko(sbacko), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_si(spi_si),
    .spi_so(spi_so)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Read-data monitor: every read ack is compared against the oldest queued expectation
  initial forever begin
    @(negedge clk);
    if (sbacko && sbrwi == SB_RD) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
      else chk(nm_q.pop_front(), sbdato, exp_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] model_sr();
    return {1'b0, ~spi_ss, m_toe, ~m_full, m_rrdy, m_roe, 2'b00};
  endfunction

  task automatic model_reset();
    foreach (m_reg[i]) m_reg[i] = 8'h00;
    m_hold = 0; m_rx = 0; m_cur = 0;
    m_full = 0; m_rrdy = 0; m_toe = 0; m_roe = 0;
  endtask

  task automatic model_start();
    m_cur = m_full ? m_hold : 8'h00;
    if (!m_full) m_toe = 1;
    m_full = 0;
  endtask

  task automatic bus(input logic rw, input logic [7:0] a, input logic [7:0] d);
    int n;
    logic [3:0] r;
    logic [7:0] e;
    r = a[3:0];
    if (rw == SB_RD) begin
      e = (r == SPISR) ? model_sr() : (r == SPIRXDR) ? m_rx :
          (r >= SPICR0 && r != SPITXDR) ? m_reg[r] : 8'h00;
      exp_q.push_back(e);
      nm_q.push_back($sformatf("read_%0h", r));
      if (r == SPISR) begin m_toe = 0; m_roe = 0; end
      if (r == SPIRXDR) m_rrdy = 0;
    end else if (r == SPITXDR) begin
      m_hold = d; m_full = 1;
    end else if (r >= SPICR0 && r != SPISR && r != SPIRXDR) m_reg[r] = d;
    @(negedge clk);
    sbrwi = rw; sbadri = a; sbdati = d; sbstbi = 1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!sbacko && n < 10);
    chk("ack_latency", n, 1);
    @(negedge clk);
    sbstbi = 0;
    @(posedge clk); #1;
    chk("ack_width", sbacko, 0);
  endtask

  task automatic ss_low();
    @(negedge clk);
    spi_ss = 0;
    model_start();
    repeat (3) @(negedge clk);
    chk("first_bit", spi_so, m_reg[SPICR2][0] ? m_cur[0] : m_cur[7]);
    repeat (5) @(negedge clk);
  endtask

  task automatic ss_high();
    @(negedge clk);
    spi_ss = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    bit l;
    l = m_reg[SPICR2][0];
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int k;
      k = l ? i : 7 - i;
      spi_si = b[k];
      repeat (8) @(negedge clk);
      got[k] = spi_so;
      spi_sck = 1;
      repeat (8) @(negedge clk);
      spi_sck = 0;
    end
  endtask

  task automatic xfer(input logic [7:0] b);
    logic [7:0] got;
    shift_bits(b, 8, got);
    chk("so_byte", got, m_cur);
    if (m_rrdy) m_roe = 1;
    m_rx = b;
    m_rrdy = 1;
    model_start();
  endtask

  initial begin
    logic [7:0] got;
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", sbacko, 0);
    chk("rst_dato", sbdato, 8'h00);
    chk("rst_so", spi_so, 1);
    rst = 0;
    repeat (5) @(negedge clk);
    // configure
    bus(SB_WR, 8'h09, 8'h80);
    bus(SB_WR, 8'h0A, 8'h01);
    bus(SB_RD, 8'h0C, 0);
    bus(SB_RD, 8'h09, 0);
    // TX, LSB first
    bus(SB_WR, 8'h0D, 8'hA5);
    ss_low();
    bus(SB_RD, 8'h0C, 0);
    xfer(8'($urandom));
    ss_high();
    bus(SB_RD, 8'h0C, 0);
    bus(SB_RD, 8'h0E, 0);
    // RX, MSB first
    bus(SB_WR, 8'h0A, 8'h00);
    ss_low();
    xfer(8'h3C);
    ss_high();
    bus(SB_RD, 8'h0C, 0);
    bus(SB_RD, 8'h0E, 0);
    bus(SB_RD, 8'h0C, 0);
    // overrun
    ss_low();
    xfer(8'h11);
    xfer(8'h22);
    ss_high();
    bus(SB_RD, 8'h0C, 0);
    bus(SB_RD, 8'h0E, 0);
    bus(SB_RD, 8'h0C, 0);
    // abort mid-byte, then a clean byte
    ss_low();
    shift_bits(8'hF0, 4, got);
    ss_high();
    bus(SB_RD, 8'h0C, 0);
    ss_low();
    xfer(8'h55);
    ss_high();
    bus(SB_RD, 8'h0E, 0);
    // randomized traffic
    repeat (40) begin
      int op, r;
      logic [7:0] d;
      op = $urandom_range(0, 4);
      r = $urandom_range(0, 15);
      d = 8'($urandom);
      if (r == 9) d = d | 8'h80;
      if (r == 10) d = d & 8'h81;
      if (op == 0) bus(SB_WR, {4'h0, 4'(r)}, d);
      else if (op == 1) bus(SB_RD, {4'h0, 4'(r)}, 0);
      else if (op == 2) bus(SB_RD, 8'h0C, 0);
      else begin
        if (op == 4) bus(SB_WR, 8'h0D, d);
        ss_low();
        repeat ($urandom_range(1, 3)) xfer(8'($urandom));
        ss_high();
        bus(SB_RD, 8'h0E, 0);
      end
    end
    // address filter: neither access may ack or take effect
    @(negedge clk);
    sbrwi = SB_RD; sbadri = 8'h1C; sbstbi = 1; n = 0;
    repeat (10) begin @(posedge clk); #1; if (sbacko) n++; end
    @(negedge clk);
    sbstbi = 0; sbrwi = SB_WR; sbadri = 8'h19; sbdati = 8'h00;
    @(negedge clk);
    sbstbi = 1;
    repeat (10) begin @(posedge clk); #1; if (sbacko) n++; end
    chk("filter_ack", n, 0);
    @(negedge clk);
    sbstbi = 0;
    bus(SB_RD, 8'h09, 0);
    bus(SB_WR, 8'h0D, 8'h96);
    ss_low();
    xfer(8'h0F);
    ss_high();
    bus(SB_RD, 8'h0E, 0);
    // reset in mid-byte
    ss_low();
    shift_bits(8'hC3, 3, got);
    @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_so", spi_so, 1);
    chk("midrst_ack", sbacko, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    spi_ss = 1;
    repeat (6) @(negedge clk);
    bus(SB_RD, 8'h0C, 0);
    bus(SB_RD, 8'h09, 0);
    bus(SB_WR, 8'h09, 8'h80);
    ss_low();
    xfer(8'h5A);
    ss_high();
    bus(SB_RD, 8'h0E, 0);
    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sb_spi.md
Name: sb_spi

Overview:
- Synthesizable model of the iCE40 hard SPI block, slave mode only, with its 8-bit system-bus register interface.
- A bus-side state machine configures it through control registers, polls SPISR, writes bytes to SPITXDR and reads SPIRXDR.
- The external SPI master drives spi_sck, spi_ss and spi_si asynchronously to clk.

Parameters:
- BUS_ADDR74, 4'b0000: block responds only when sbadri[7:4] equals this value.

Ports:
- clk  in  1  system clock; must be at least 8x the spi_sck frequency.
- rst  in  1  asynchronous, active-high reset.
- sbrwi  in  1  1 = write, 0 = read.
- sbstbi  in  1  bus strobe; held high until acknowledged.
- sbadri  in  8  register address.
- sbdati  in  8  write data.
- sbdato  out  8  read data.
- sbacko  out  1  acknowledge pulse.
- spi_sck  in  1  SPI clock from the master.
- spi_ss  in  1  chip select, active low.
- spi_si  in  1  MOSI.
- spi_so  out  1  MISO.

Behaviour:
- Register map (low nibble of sbadri):
  - 0x8 SPICR0: stored, no effect.
  - 0x9 SPICR1: bit7 SPE enables the core.
  - 0xA SPICR2: bit7 MSTR stored and ignored; bit2 CPOL; bit1 CPHA; bit0 LSBF.
  - 0xB SPIBR: stored.
  - 0xC SPISR: read-only.
  - 0xD SPITXDR: write-only.
  - 0xE SPIRXDR: read-only.
  - 0xF SPICSR: stored.
  - Other low-nibble addresses: reads return 0x00, writes ignored, still acked.
- SPISR bits: bit7 TIP, bit6 BUSY, bit5 TOE, bit4 TRDY, bit3 RRDY, bit2 ROE; other bits read 0.
- Bus handshake:
  - sbstbi high with matching BUS_ADDR74 -> sbacko high for exactly 1 cycle, on the cycle after sbstbi is first sampled high.
  - sbdato is valid in that same cycle and is 0x00 otherwise.
  - The write or read side effect happens once, on the ack cycle.
  - No further ack until sbstbi has been sampled low.
  - Non-matching address: no ack, no side effect.
- Synchronisation: spi_sck, spi_ss and spi_si each pass through 2-flop synchronisers; edges are detected in the clk domain.
- SPI engine, active when SPE=1 and spi_ss is low:
  - Mode 0: sample spi_si on the rising edge of spi_sck, shift spi_so on the falling edge.
  - LSBF=1 shifts bit 0 first; LSBF=0 shifts bit 7 first.
  - First bit is presented on spi_so within 3 clk cycles of spi_ss falling.
- TX path:
  - Writing SPITXDR fills the holding register and clears TRDY.
  - At each byte start (spi_ss fall, or the 8th bit of the previous byte completing), holding moves to the shifter and TRDY is set.
  - If holding is empty at byte start, shift 0x00 and set TOE.
- RX path:
  - After 8 sampled bits, the byte goes to SPIRXDR and RRDY is set.
  - If RRDY was already 1, set ROE and overwrite.
  - Reading SPIRXDR clears RRDY. Reading SPISR clears TOE and ROE.
- TIP is 1 while the bit counter is nonzero. BUSY = TIP OR (spi_ss low).
- spi_ss rising mid-byte: partial byte discarded, bit counter cleared, holding retained.
- spi_so: drives 1 while spi_ss is high or SPE=0. With SPE=0, SCK edges are ignored.
- Simultaneous events:
  - SPITXDR write in the cycle holding is transferred: transfer first, then the new data fills holding; TRDY ends 0.
  - SPIRXDR read in the cycle a new byte lands: new byte stored, RRDY stays 1, no ROE.
- Reset values:
  - All registers 0x00; holding and shifter 0x00; bit counter 0.
  - TRDY=1; RRDY, TOE, ROE = 0.
  - sbacko=0, sbdato=0x00, spi_so=1.
- Reset mid-transfer: everything returns to reset values; reception resumes only at the next spi_ss falling edge.

Optional Feature:
- SB_SPI_MODES_EN defined: CPOL/CPHA honoured for all four SPI modes. CPHA=1 shifts on the leading edge and samples on the trailing edge; CPOL inverts the idle level.
- Undefined: CPOL/CPHA are stored but the engine is fixed to mode 0.

Decomposition:
- Package sb_spi_pkg holds:
  - register offset constants (SPICR0..SPICSR);
  - SPISR bit indices (TIP=7, BUSY=6, TOE=5, TRDY=4, RRDY=3, ROE=2);
  - SB_WR=1, SB_RD=0.
- Sub-module sb_spi_shifter holds the synchronisers, edge detect, bit counter, shifter and byte-done/byte-start pulses.
- The top level holds the bus FSM, registers and status flags.

Test Plan:
- Configure: write SPICR1=0x80, SPICR2=0x01 -> each access acked exactly 1 cycle after strobe; SPISR reads 0x10.
- TX LSBF: write SPITXDR=0xA5; master clocks 8 bits -> spi_so sequence 1,0,1,0,0,1,0,1; TRDY=1 after the byte starts.
- RX: master sends 0x3C MSB-first with LSBF=0 -> RRDY=1; SPIRXDR reads 0x3C; RRDY=0 afterwards.
- Overrun: two bytes 0x11, 0x22 with no read -> SPISR ROE=1; SPIRXDR reads 0x22; next SPISR read shows ROE=0.
- Abort: spi_ss raised after 4 bits -> no RRDY; next full byte 0x55 is received intact.
- Address filter and reset: strobe at 0x1C with BUS_ADDR74=0 -> no ack in 10 cycles; assert rst mid-byte -> SPISR=0x10, spi_so=1.
